// File: rtl/pipe_if_stage.sv
// pipe_if_stage: instruction fetch stage with PC register, next-PC mux,
// local instruction RAM, IF/ID register and IDLE/RUN host-load control.
// Ports: clk, rst (sync, active high); start/halt run control;
//   stall/flush from ID; pcsource, pc_jr, imm18, index28 redirects;
//   ram_wena/ram_waddr/ram_indata host load; pc, id_inst, id_pc4,
//   id_pc8, id_valid, running outputs.
// Option PIPE_IF_MISALIGN_TRAP_EN: adds fetch_fault; misaligned jr traps
//   to IDLE instead of having its low bits masked.
module pipe_if_stage #(
   parameter int          DATA_W   = 32,
   parameter int          IMEM_AW  = 3,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                halt,
   input  logic                stall,
   input  logic                flush,
   input  logic [1:0]          pcsource,
   input  logic [DATA_W-1:0]   pc_jr,
   input  logic [17:0]         imm18,
   input  logic [27:0]         index28,
   input  logic                ram_wena,
   input  logic [IMEM_AW-1:0]  ram_waddr,
   input  logic [DATA_W-1:0]   ram_indata,
   output logic [DATA_W-1:0]   pc,
   output logic [DATA_W-1:0]   id_inst,
   output logic [DATA_W-1:0]   id_pc4,
   output logic [DATA_W-1:0]   id_pc8,
   output logic                id_valid,
   output logic                running
`ifdef PIPE_IF_MISALIGN_TRAP_EN
   ,
   output logic                fetch_fault
`endif
);

   localparam int DEPTH = 2 ** IMEM_AW;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] r_id_inst;
   logic [DATA_W-1:0] r_id_pc4;
   logic [DATA_W-1:0] r_id_pc8;
   logic              r_id_valid;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_run;
   logic              w_halt_run;
   logic              w_adv;
   logic              w_trap;
   logic [1:0]        w_sel;
   logic [DATA_W-1:0] w_inst;
   logic [DATA_W-1:0] w_pc4;
   logic [DATA_W-1:0] w_pc8;
   logic [DATA_W-1:0] w_br_tgt;
   logic [DATA_W-1:0] w_j_tgt;
   logic [DATA_W-1:0] w_jr_tgt;
   logic [DATA_W-1:0] w_pc_nxt;

   assign w_run      = (r_state == S_RUN);
   assign w_halt_run = w_run & halt;
   // Fetch advances only in RUN without stall; halt overrides everything.
   assign w_adv      = w_run & ~halt & ~stall;

   // Redirects are only meaningful for a valid instruction in ID.
   assign w_sel    = r_id_valid ? pcsource : 2'd0;
   assign w_inst   = r_mem[r_pc[IMEM_AW+1:2]];
   assign w_pc4    = r_pc + 32'd4;
   assign w_pc8    = r_pc + 32'd8;
   assign w_br_tgt = r_id_pc4 + {{(DATA_W-18){imm18[17]}}, imm18};
   assign w_j_tgt  = {r_id_pc4[DATA_W-1:28], index28};

`ifdef PIPE_IF_MISALIGN_TRAP_EN
   assign w_jr_tgt = pc_jr;
   assign w_trap   = w_adv & (w_sel == 2'd1) & (pc_jr[1:0] != 2'b00);
`else
   assign w_jr_tgt = pc_jr & ~32'd3;
   assign w_trap   = 1'b0;
`endif

   always_comb begin
      w_pc_nxt = w_pc4;
      unique case (w_sel)
         2'd0: w_pc_nxt = w_pc4;
         2'd1: w_pc_nxt = w_jr_tgt;
         2'd2: w_pc_nxt = w_br_tgt;
         2'd3: w_pc_nxt = w_j_tgt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      running     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start && !halt) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            running = 1'b1;
            if (halt || w_trap) w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (w_halt_run) begin
         r_pc <= RESET_PC;
      end else if (w_adv) begin
         r_pc <= w_pc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_id_inst  <= '0;
         r_id_pc4   <= '0;
         r_id_pc8   <= '0;
         r_id_valid <= 1'b0;
      end else if (w_halt_run || w_trap) begin
         r_id_valid <= 1'b0;
      end else if (w_adv) begin
         r_id_inst  <= w_inst;
         r_id_pc4   <= w_pc4;
         r_id_pc8   <= w_pc8;
         r_id_valid <= ~flush;
      end else if (w_run && flush) begin
         r_id_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!w_run && ram_wena) r_mem[ram_waddr] <= ram_indata;
   end

`ifdef PIPE_IF_MISALIGN_TRAP_EN
   logic r_fault;
   always_ff @(posedge clk) begin
      if (rst)                  r_fault <= 1'b0;
      else if (w_trap)          r_fault <= 1'b1;
      else if (!w_run && start) r_fault <= 1'b0;
   end
   assign fetch_fault = r_fault;
`endif

   assign pc       = r_pc;
   assign id_inst  = r_id_inst;
   assign id_pc4   = r_id_pc4;
   assign id_pc8   = r_id_pc8;
   assign id_valid = r_id_valid;

endmodule

// File: doc/pipe_if_stage.md
Name: pipe_if_stage

Overview:
- Parametrised instruction-fetch stage with its own PC register, next-PC selection, a local instruction RAM and the IF/ID pipeline register.
- Sits ahead of the ID stage. It takes redirects from ID (jr, beq/bne, j/jal) and presents to ID the instruction, pc+4, pc+8 (return address for the delay slot) and a valid bit.
- A small run-control FSM lets a host load the instruction RAM before execution starts.

Parameters:
- DATA_W, 32, PC and instruction width (fixed at 32; other values unsupported).
- IMEM_AW, 3, instruction RAM address bits (depth = 2**IMEM_AW words).
- RESET_PC, 32'h0000_0000, PC value after reset and after halt.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  IDLE->RUN request.
- halt  in  1  RUN->IDLE request.
- stall  in  1  hold PC and IF/ID (load-use hazard from ID).
- flush  in  1  invalidate the IF/ID entry.
- pcsource  in  2  next-PC select: 0 = pc+4, 1 = jr, 2 = branch, 3 = jump.
- pc_jr  in  32  jr target from the register file.
- imm18  in  18  branch offset (offset16 << 2), two's complement.
- index28  in  28  jump index (index26 << 2).
- ram_wena  in  1  host write strobe.
- ram_waddr  in  IMEM_AW  host write word address.
- ram_indata  in  32  host write data.
- pc  out  32  current fetch PC.
- id_inst  out  32  IF/ID instruction.
- id_pc4  out  32  IF/ID pc+4.
- id_pc8  out  32  IF/ID pc+8.
- id_valid  out  1  IF/ID entry valid.
- running  out  1  FSM is in RUN.

Behaviour:
- Reset (rst=1 at a clock edge): pc=RESET_PC, id_inst=0, id_pc4=0, id_pc8=0, id_valid=0, state=IDLE, running=0. RAM contents are not cleared.
- FSM states:
  - IDLE: PC and IF/ID are frozen and id_valid=0. Host writes are accepted.
  - RUN: fetching. Host writes are ignored and the RAM is unchanged.
- FSM transitions:
  - IDLE->RUN on start.
  - RUN->IDLE on halt. halt has priority over start when both are high.
  - On entering IDLE, pc<=RESET_PC and id_valid<=0 in the same edge.
- RAM:
  - Synchronous write, taken in IDLE only.
  - Combinational read at word address pc[IMEM_AW+1:2].
  - PC bits above IMEM_AW+1 are ignored, so addresses alias (wrap-around).
- Arithmetic (all 32-bit, carries dropped):
  - pc4 = pc+4, pc8 = pc+8.
  - Branch target = id_pc4 + sign_extend(imm18).
  - Jump target = {id_pc4[31:28], index28}.
  - jr target = pc_jr.
  - Branch and jump targets are relative to the instruction in ID, with delay-slot semantics: the slot instruction is fetched normally and never auto-flushed.
- RUN, stall=0, each edge:
  - pc <= target selected by pcsource.
  - id_inst <= RAM[pc], id_pc4 <= pc4, id_pc8 <= pc8, id_valid <= ~flush.
  - pcsource/targets are ignored (treated as 0) when id_valid=0.
- RUN, stall=1:
  - pc and the IF/ID data fields hold, and pcsource is ignored; ID re-presents the redirect after the stall.
  - flush still clears id_valid.
- flush+stall together: id_valid<=0, data fields hold, pc holds.
- Latency: one cycle from PC to IF/ID. A redirect presented in cycle n makes pc equal the target in cycle n+1.
- Misaligned jr: without the option, pc_jr[1:0] is forced to 0.

Optional Feature:
- Macro: PIPE_IF_MISALIGN_TRAP_EN.
- When defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A jr redirect (RUN, stall=0, id_valid=1, pcsource=1) with pc_jr[1:0]!=0 sets fetch_fault=1, loads the unmasked pc_jr into pc, and the FSM enters IDLE next edge (id_valid=0).
  - fetch_fault is sticky until rst or start.
- When not defined: there is no fetch_fault port, and low bits are masked as above.

Test Plan:
- Load and run: load RAM[0..7]=32'h1000_0000+i in IDLE, then pulse start → id_inst sequence 0x10000000, 0x10000001, ..., with id_pc4=4, 8, ... and id_valid=1 from the 2nd RUN cycle.
- Wrap-around with IMEM_AW=3: run 9 sequential fetches → pc=0x20 fetches RAM[0] (aliasing), and id_pc4=0x24.
- Branch: id_pc4=0x8, imm18=18'h3FFF8 (-8), pcsource=2 → next pc=0x0; the delay-slot instruction at 0x8 stays id_valid=1.
- Jump: id_pc4=0x8000_0004, index28=28'h000_0010, pcsource=3 → pc=0x8000_0010.
- Stall/flush: stall=1 for 3 cycles with pcsource=3 → pc and id_inst unchanged. Then stall=1 with flush=1 → id_valid=0 and pc held.
- Control: halt in mid-run → pc=RESET_PC and running=0 next edge. A host write during RUN leaves the RAM unchanged. rst during RUN → all outputs at their reset values. With PIPE_IF_MISALIGN_TRAP_EN: jr to 0x6 → fetch_fault=1 and running=0.
